// File: rtl/booth_mul_arbiter.sv
// Round-robin arbiter/sequencer sharing one sequential signed 8x8 multiplier core among NREQ requesters.
// Optional WAIT-state abort counter enabled by defining BOOTH_ARB_TIMEOUT_EN.
module booth_mul_arbiter #(
   parameter int NREQ    = 4,
   parameter int TIMEOUT = 32
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic [NREQ-1:0]          req_valid,
   output logic [NREQ-1:0]          req_ready,
   input  logic [8*NREQ-1:0]        req_a,
   input  logic [8*NREQ-1:0]        req_b,
   output logic                     mul_load,
   output logic [7:0]               mul_a,
   output logic [7:0]               mul_b,
   input  logic                     mul_done,
   input  logic [15:0]              mul_p,
   output logic                     rsp_valid,
   input  logic                     rsp_ready,
   output logic [$clog2(NREQ)-1:0]  rsp_id,
   output logic [15:0]              rsp_p,
   output logic                     rsp_err
);

   localparam int IDW = $clog2(NREQ);

   if (NREQ < 2 || NREQ > 8 || TIMEOUT < 1) begin : g_param_check
      $error("booth_mul_arbiter: NREQ must be 2..8 and TIMEOUT at least 1");
   end

   typedef enum logic [1:0] {S_IDLE, S_LOAD, S_WAIT, S_RESP} state_t;

   state_t          state;
   logic [IDW-1:0]  ptr;
   logic [IDW-1:0]  win;
   logic [IDW-1:0]  cand;
   logic [IDW-1:0]  ptr_next;
   logic            found;
   logic            accept;

   // Rotating-priority search: first valid index at or after ptr, wrapping modulo NREQ.
   // NOTE: every always_comb output gets a default first so no path can infer a latch.
   always_comb begin
      win   = '0;
      cand  = '0;
      found = 1'b0;
      for (int k = 0; k < NREQ; k++) begin
         cand = IDW'((int'(ptr) + k) % NREQ);
         if (!found && req_valid[cand]) begin
            found = 1'b1;
            win   = cand;
         end
      end
   end

   assign accept   = (state == S_IDLE) && found;
   assign ptr_next = (win == IDW'(NREQ - 1)) ? '0 : win + 1'b1;

   always_comb begin
      req_ready = '0;
      if (accept) req_ready[win] = 1'b1;
   end

`ifdef BOOTH_ARB_TIMEOUT_EN
   localparam int CNT_W = $clog2(TIMEOUT + 1);
   logic [CNT_W-1:0] wait_cnt;
`else
   assign rsp_err = 1'b0;
`endif

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= S_IDLE;
         ptr       <= '0;
         mul_load  <= 1'b0;
         mul_a     <= '0;
         mul_b     <= '0;
         rsp_valid <= 1'b0;
         rsp_id    <= '0;
         rsp_p     <= '0;
`ifdef BOOTH_ARB_TIMEOUT_EN
         rsp_err   <= 1'b0;
         wait_cnt  <= '0;
`endif
      end else begin
         mul_load <= 1'b0;
         unique case (state)
            S_IDLE: begin
               if (accept) begin
                  mul_a    <= req_a[8*win +: 8];
                  mul_b    <= req_b[8*win +: 8];
                  rsp_id   <= win;
                  ptr      <= ptr_next;
                  mul_load <= 1'b1;
                  state    <= S_LOAD;
               end
            end
            S_LOAD: begin
               // A done seen here belongs to the core's previous state and is dropped.
`ifdef BOOTH_ARB_TIMEOUT_EN
               wait_cnt <= '0;
`endif
               state <= S_WAIT;
            end
            S_WAIT: begin
               if (mul_done) begin
                  rsp_p     <= mul_p;
                  rsp_valid <= 1'b1;
                  state     <= S_RESP;
`ifdef BOOTH_ARB_TIMEOUT_EN
                  rsp_err   <= 1'b0;
               end else if (wait_cnt == CNT_W'(TIMEOUT - 1)) begin
                  rsp_p     <= '0;
                  rsp_err   <= 1'b1;
                  rsp_valid <= 1'b1;
                  state     <= S_RESP;
               end else begin
                  wait_cnt  <= wait_cnt + 1'b1;
`endif
               end
            end
            S_RESP: begin
               if (rsp_ready) begin
                  rsp_valid <= 1'b0;
                  state     <= S_IDLE;
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_booth_mul_arbiter.sv
// Directed self-checking bench for booth_mul_arbiter with a behavioral multiplier core model.
// Expectations for the abort path follow BOOTH_ARB_TIMEOUT_EN.
module tb_booth_mul_arbiter;

   localparam int NREQ = 4;

   logic              clk = 1'b0;
   logic              reset;
   logic [NREQ-1:0]   req_valid;
   logic [NREQ-1:0]   req_ready;
   logic [8*NREQ-1:0] req_a;
   logic [8*NREQ-1:0] req_b;
   logic              mul_load;
   logic [7:0]        mul_a;
   logic [7:0]        mul_b;
   logic              mul_done = 1'b0;
   logic [15:0]       mul_p = '0;
   logic              rsp_valid;
   logic              rsp_ready;
   logic [1:0]        rsp_id;
   logic [15:0]       rsp_p;
   logic              rsp_err;

   int n_vec = 0;
   int n_err = 0;
   int loads = 0;

   // core model knobs
   bit          core_en   = 1'b1;
   bit          core_spur = 1'b0;
   int          core_lat  = 1;
   bit          core_busy = 1'b0;
   int          core_cnt  = 0;
   logic signed [15:0] core_prod = '0;

   booth_mul_arbiter #(.NREQ(NREQ), .TIMEOUT(32)) dut (
      .clk       (clk),
      .reset     (reset),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_a     (req_a),
      .req_b     (req_b),
      .mul_load  (mul_load),
      .mul_a     (mul_a),
      .mul_b     (mul_b),
      .mul_done  (mul_done),
      .mul_p     (mul_p),
      .rsp_valid (rsp_valid),
      .rsp_ready (rsp_ready),
      .rsp_id    (rsp_id),
      .rsp_p     (rsp_p),
      .rsp_err   (rsp_err)
   );

   always #5 clk = ~clk;

   // Sequential core: latches operands on load, pulses done core_lat cycles later.
   always @(negedge clk) begin
      mul_done = 1'b0;
      if (mul_load) begin
         loads     = loads + 1;
         core_busy = 1'b1;
         core_cnt  = 0;
         core_prod = $signed(mul_a) * $signed(mul_b);
         if (core_spur) begin
            mul_done = 1'b1;
            mul_p    = 16'h1234;
         end
      end else if (core_busy && core_en) begin
         core_cnt = core_cnt + 1;
         if (core_cnt >= core_lat) begin
            mul_done  = 1'b1;
            mul_p     = core_prod;
            core_busy = 1'b0;
         end
      end
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_rsp(input int budget, output int n);
      n = 0;
      while (!rsp_valid && n < budget) begin
         step();
         n++;
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      int seen;
      reset     = 1'b1;
      req_valid = '0;
      req_a     = '0;
      req_b     = '0;
      rsp_ready = 1'b0;
      repeat (2) step();

      check("rst_req_ready", req_ready, 0);
      check("rst_mul_load",  mul_load,  0);
      check("rst_mul_a",     mul_a,     0);
      check("rst_mul_b",     mul_b,     0);
      check("rst_rsp_valid", rsp_valid, 0);
      check("rst_rsp_id",    rsp_id,    0);
      check("rst_rsp_p",     rsp_p,     0);
      check("rst_rsp_err",   rsp_err,   0);
      reset = 1'b0;
      step();

      // single request: req 2, -3 * 7
      core_lat = 17;
      loads    = 0;
      req_a[23:16] = 8'hFD;
      req_b[23:16] = 8'h07;
      req_valid    = 4'b0100;
      #1;
      check("t1_grant",      req_ready, 4'b0100);
      check("t1_load_early", mul_load,  0);
      step();
      req_valid = '0;
      check("t1_load", mul_load, 1);
      check("t1_mul_a", mul_a, 8'hFD);
      check("t1_mul_b", mul_b, 8'h07);
      wait_rsp(100, n);
      check("t1_latency", n, 18);
      check("t1_rsp_id",  rsp_id,  2);
      check("t1_rsp_p",   rsp_p,   16'hFFEB);
      check("t1_rsp_err", rsp_err, 0);
      rsp_ready = 1'b1;
      step();
      check("t1_rsp_clear", rsp_valid, 0);
      check("t1_load_count", loads, 1);

      // round robin from ptr=0
      reset = 1'b1;
      step();
      reset = 1'b0;
      core_lat = 3;
      for (int i = 0; i < NREQ; i++) begin
         req_a[8*i +: 8] = 8'(i + 1);
         req_b[8*i +: 8] = 8'd2;
      end
      req_valid = 4'b1111;
      for (int k = 0; k < 5; k++) begin
         wait_rsp(50, n);
         check($sformatf("rr%0d_valid", k), rsp_valid, 1);
         check($sformatf("rr%0d_id", k), rsp_id, k % 4);
         check($sformatf("rr%0d_p", k), rsp_p, ((k % 4) + 1) * 2);
         if (k == 4) req_valid = '0;
         step();
      end

      // backpressure: req 3 served (ptr=1), req 1 waits behind a stalled response
      rsp_ready    = 1'b0;
      req_a[31:24] = 8'h05;
      req_b[31:24] = 8'hFE;
      req_valid    = 4'b1000;
      #1;
      check("bp_grant3", req_ready, 4'b1000);
      step();
      req_a[15:8] = 8'h02;
      req_b[15:8] = 8'h02;
      req_valid   = 4'b0010;
      wait_rsp(50, n);
      check("bp_valid", rsp_valid, 1);
      for (int c = 0; c < 10; c++) begin
         check($sformatf("bp%0d_valid", c), rsp_valid, 1);
         check($sformatf("bp%0d_id", c), rsp_id, 3);
         check($sformatf("bp%0d_p", c), rsp_p, 16'hFFF6);
         check($sformatf("bp%0d_ready", c), req_ready, 0);
         step();
      end
      rsp_ready = 1'b1;
      step();
      check("bp_grant1", req_ready, 4'b0010);
      step();
      req_valid = '0;
      wait_rsp(50, n);
      check("bp_id1", rsp_id, 1);
      check("bp_p1",  rsp_p,  16'h0004);
      step();

      // -128 * -128 with a spurious done during LOAD
      core_spur  = 1'b1;
      core_lat   = 5;
      req_a[7:0] = 8'h80;
      req_b[7:0] = 8'h80;
      req_valid  = 4'b0001;
      #1;
      check("bd_grant0", req_ready, 4'b0001);
      step();
      req_valid = '0;
      wait_rsp(50, n);
      check("bd_latency", n, 6);
      check("bd_rsp_p",   rsp_p, 16'h4000);
      check("bd_rsp_id",  rsp_id, 0);
      step();
      core_spur = 1'b0;

      // reset three cycles after load, core finishes later
      core_lat     = 8;
      req_a[23:16] = 8'h03;
      req_b[23:16] = 8'h03;
      req_valid    = 4'b0100;
      #1;
      check("mr_grant2", req_ready, 4'b0100);
      step();
      req_valid = '0;
      repeat (3) step();
      reset = 1'b1;
      step();
      check("mr_rsp_valid", rsp_valid, 0);
      check("mr_mul_a",     mul_a,     0);
      check("mr_rsp_id",    rsp_id,    0);
      reset = 1'b0;
      seen = 0;
      repeat (12) begin
         step();
         if (rsp_valid) seen++;
      end
      check("mr_no_rsp", seen, 0);
      req_valid = 4'b1111;
      #1;
      check("mr_ptr_grant0", req_ready, 4'b0001);
      req_valid = '0;
      step();

      // core never completes
      core_en     = 1'b0;
      req_a[15:8] = 8'h01;
      req_b[15:8] = 8'h01;
      req_valid   = 4'b0010;
      step();
      req_valid = '0;
      check("to_load", mul_load, 1);
      wait_rsp(1000, n);
`ifdef BOOTH_ARB_TIMEOUT_EN
      check("to_valid",   rsp_valid, 1);
      check("to_latency", n, 33);
      check("to_err",     rsp_err, 1);
      check("to_p",       rsp_p, 0);
      check("to_id",      rsp_id, 1);
      step();
      check("to_clear",   rsp_valid, 0);
`else
      check("to_off_no_rsp", rsp_valid, 0);
`endif

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
